// File: rtl/uart_rx_param_if.sv
// Receive-side handshake and status bundle of uart_rx_param.
// The receiver drives the word, its valid flag and the status pulses; the consumer drives rx_ready.
interface uart_rx_param_if #(
    parameter int P_DATA_BITS = 8
);
    logic [P_DATA_BITS-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   err_frame;
    logic                   err_parity;
    logic                   err_overrun;
    logic                   rx_break;
    logic                   busy;

    modport master (
        output rx_data, rx_valid, err_frame, err_parity, err_overrun, rx_break, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, err_frame, err_parity, err_overrun, rx_break, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver using 16x oversampling and a 2-of-3 majority vote per bit.
// It also detects false starts, parity errors, framing errors, overrun and line break.
module uart_rx_param #(
    parameter int P_DATA_BITS = 8,
    parameter int P_PARITY    = 0,
    parameter int P_STOP_BITS = 1,
    parameter int P_DIV_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_DIV_W-1:0] baud_div,
    input  logic               uart_in,
    uart_rx_param_if.master    rx
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                 state_q;
    logic                   sync1_q, sync2_q, prev_q;
    logic [P_DIV_W-1:0]     div_q, div_cnt_q;
    logic [3:0]             tick_cnt_q, bit_cnt_q;
    logic [1:0]             samp_q;
    logic [P_DATA_BITS-1:0] shreg_q, data_q;
    logic                   perr_q, ferr_q, zero_q, fin_q, busy_q, valid_q;
    logic                   err_frame_q, err_parity_q, err_overrun_q, break_q;

    logic run_d, tick_d, dec_d, bit_d, par_exp_d, load_d;

    always_comb begin
        run_d     = (state_q != S_IDLE) && (state_q != S_BREAK);
        tick_d    = run_d && (div_cnt_q == div_q);
        dec_d     = tick_d && (tick_cnt_q == 4'd9);
        bit_d     = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);
        par_exp_d = (P_PARITY == 2) ? ~(^shreg_q) : ^shreg_q;
        load_d    = fin_q & ~zero_q & ~ferr_q & (~valid_q | rx.rx_ready);
    end

    // Receive FSM: the tick counter runs freely across bit boundaries once a start is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            div_q      <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fin_q   <= 1'b0;
            if (run_d) begin
                if (tick_d) begin
                    div_cnt_q  <= '0;
                    tick_cnt_q <= tick_cnt_q + 4'd1;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
                if (tick_d && (tick_cnt_q == 4'd7 || tick_cnt_q == 4'd8))
                    samp_q <= {samp_q[0], sync2_q};
            end
            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q    <= S_START;
                        div_q      <= baud_div;
                        div_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        zero_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    if (dec_d) begin
                        if (bit_d) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (dec_d) begin
                        shreg_q   <= {bit_d, shreg_q[P_DATA_BITS-1:1]};
                        zero_q    <= zero_q & ~bit_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(P_DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= (P_PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (dec_d) begin
                        perr_q  <= (bit_d != par_exp_d);
                        zero_q  <= zero_q & ~bit_d;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (dec_d) begin
                        ferr_q    <= ferr_q | ~bit_d;
                        zero_q    <= zero_q & ~bit_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(P_STOP_BITS - 1)) begin
                            fin_q <= 1'b1;
                            if (zero_q && !bit_d) begin
                                state_q <= S_BREAK;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Frame completion: break beats framing error, which beats delivery or overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q        <= '0;
            valid_q       <= 1'b0;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            break_q       <= 1'b0;
        end else begin
            err_frame_q   <= fin_q & ~zero_q & ferr_q;
            err_overrun_q <= fin_q & ~zero_q & ~ferr_q & valid_q & ~rx.rx_ready;
            break_q       <= fin_q & zero_q;
            err_parity_q  <= load_d & perr_q;
            if (load_d) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.err_frame   = err_frame_q;
    assign rx.err_parity  = err_parity_q;
    assign rx.err_overrun = err_overrun_q;
    assign rx.rx_break    = break_q;
    assign rx.busy        = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver (A) and an 8E1 receiver (B) on separate lines.
module tb_uart_rx_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        line_a = 1'b1;
    logic        line_b = 1'b1;

    uart_rx_param_if #(.P_DATA_BITS(8)) ifa ();
    uart_rx_param_if #(.P_DATA_BITS(8)) ifb ();

    uart_rx_param #(.P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1), .P_DIV_W(16)) dut_a (
        .clk(clk), .rst(rst), .baud_div(baud_div), .uart_in(line_a), .rx(ifa.master));
    uart_rx_param #(.P_DATA_BITS(8), .P_PARITY(1), .P_STOP_BITS(1), .P_DIV_W(16)) dut_b (
        .clk(clk), .rst(rst), .baud_div(baud_div), .uart_in(line_b), .rx(ifb.master));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int vcyc_a = 0, vrise_a = 0, ferr_a = 0, perr_a = 0, ovr_a = 0, brk_a = 0;
    int busy_fall_a = 0, vrise_cyc_a = 0;
    logic [7:0] last_a = 8'h00;
    logic pv_a = 1'b0, pb_a = 1'b0;
    int vrise_b = 0, ferr_b = 0, perr_b = 0, perr_load_b = 0;
    logic [7:0] last_b = 8'h00;
    logic pv_b = 1'b0;

    always @(negedge clk) begin
        if (ifa.rx_valid) vcyc_a++;
        if (ifa.rx_valid && !pv_a) begin vrise_a++; last_a = ifa.rx_data; vrise_cyc_a = cyc; end
        if (!ifa.busy && pb_a) busy_fall_a = cyc;
        if (ifa.err_frame) ferr_a++;
        if (ifa.err_parity) perr_a++;
        if (ifa.err_overrun) ovr_a++;
        if (ifa.rx_break) brk_a++;
        pv_a = ifa.rx_valid;
        pb_a = ifa.busy;
        if (ifb.rx_valid && !pv_b) begin vrise_b++; last_b = ifb.rx_data; end
        if (ifb.err_frame) ferr_b++;
        if (ifb.err_parity) perr_b++;
        if (ifb.err_parity && ifb.rx_valid && !pv_b) perr_load_b++;
        pv_b = ifb.rx_valid;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int ncyc);
        if (sel) line_b = v; else line_a = v;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    // par < 0 means no parity bit on the line.
    task automatic send(input bit sel, input logic [7:0] d, input int par, input logic stop);
        int per;
        per = 16 * (int'(baud_div) + 1);
        drive_bit(sel, 1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], per);
        if (par >= 0) drive_bit(sel, par[0], per);
        drive_bit(sel, stop, per);
        drive_bit(sel, 1'b1, 2 * per);
    endtask

    typedef struct {
        int         div;
        logic [7:0] data;
        logic       stop;
        int         exp_vrise;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_brk;
    } vec_t;

    vec_t vecs[6];
    int s_vr, s_fe, s_pe, s_ov, s_br, s_vc, s_vb, s_fb, s_pb, s_plb;

    task automatic snap();
        s_vr = vrise_a; s_fe = ferr_a; s_pe = perr_a; s_ov = ovr_a; s_br = brk_a; s_vc = vcyc_a;
        s_vb = vrise_b; s_fb = ferr_b; s_pb = perr_b; s_plb = perr_load_b;
    endtask

    initial begin
        vecs[0] = '{div: 0, data: 8'hFF, stop: 1'b1, exp_vrise: 1, exp_data: 8'hFF, exp_ferr: 0, exp_brk: 0};
        vecs[1] = '{div: 0, data: 8'h00, stop: 1'b1, exp_vrise: 1, exp_data: 8'h00, exp_ferr: 0, exp_brk: 0};
        vecs[2] = '{div: 3, data: 8'h81, stop: 1'b1, exp_vrise: 1, exp_data: 8'h81, exp_ferr: 0, exp_brk: 0};
        vecs[3] = '{div: 3, data: 8'h7E, stop: 1'b0, exp_vrise: 0, exp_data: 8'h00, exp_ferr: 1, exp_brk: 0};
        vecs[4] = '{div: 1, data: 8'h5A, stop: 1'b1, exp_vrise: 1, exp_data: 8'h5A, exp_ferr: 0, exp_brk: 0};
        vecs[5] = '{div: 0, data: 8'h00, stop: 1'b0, exp_vrise: 0, exp_data: 8'h00, exp_ferr: 0, exp_brk: 1};

        ifa.rx_ready = 1'b1;
        ifb.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, ifa.rx_valid}, 32'd0);
        chk("reset_data", {24'd0, ifa.rx_data}, 32'd0);
        chk("reset_busy", {31'd0, ifa.busy}, 32'd0);
        chk("reset_errs", {28'd0, ifa.err_frame, ifa.err_parity, ifa.err_overrun, ifa.rx_break}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            baud_div = 16'(vecs[i].div);
            snap();
            send(1'b0, vecs[i].data, -1, vecs[i].stop);
            chk($sformatf("vec%0d_valid", i), vrise_a - s_vr, vecs[i].exp_vrise);
            chk($sformatf("vec%0d_ferr", i), ferr_a - s_fe, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_brk", i), brk_a - s_br, vecs[i].exp_brk);
            if (vecs[i].exp_vrise != 0) chk($sformatf("vec%0d_data", i), {24'd0, last_a}, {24'd0, vecs[i].exp_data});
        end
        chk("vec_idle_busy", {31'd0, ifa.busy}, 32'd0);

        // 8N1 at baud_div=26, 0xA5.
        baud_div = 16'd26;
        snap();
        send(1'b0, 8'hA5, -1, 1'b1);
        chk("a5_data", {24'd0, last_a}, 32'hA5);
        chk("a5_valid_cycles", vcyc_a - s_vc, 1);
        chk("a5_errs", (ferr_a - s_fe) + (perr_a - s_pe) + (ovr_a - s_ov) + (brk_a - s_br), 0);
        chk("a5_busy_before_load", vrise_cyc_a - busy_fall_a, 1);

        // Even parity, 0x03 with a wrong parity bit of 1.
        snap();
        send(1'b1, 8'h03, 1, 1'b1);
        chk("par_valid", vrise_b - s_vb, 1);
        chk("par_data", {24'd0, last_b}, 32'h03);
        chk("par_err", perr_b - s_pb, 1);
        chk("par_err_at_load", perr_load_b - s_plb, 1);
        chk("par_ferr", ferr_b - s_fb, 0);

        // Stop bit low.
        snap();
        send(1'b0, 8'h55, -1, 1'b0);
        chk("fe_pulse", ferr_a - s_fe, 1);
        chk("fe_no_valid", vrise_a - s_vr, 0);
        chk("fe_valid_low", {31'd0, ifa.rx_valid}, 32'd0);

        // Overrun.
        ifa.rx_ready = 1'b0;
        snap();
        send(1'b0, 8'h11, -1, 1'b1);
        send(1'b0, 8'h22, -1, 1'b1);
        chk("ovr_pulse", ovr_a - s_ov, 1);
        chk("ovr_data_kept", {24'd0, ifa.rx_data}, 32'h11);
        chk("ovr_valid_held", {31'd0, ifa.rx_valid}, 32'd1);
        @(negedge clk);
        ifa.rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_valid_cleared", {31'd0, ifa.rx_valid}, 32'd0);
        chk("ovr_data_retained", {24'd0, ifa.rx_data}, 32'h11);
        #1;

        // False start: 4 ticks low.
        snap();
        drive_bit(1'b0, 1'b0, 54);
        chk("glitch_busy_hi", {31'd0, ifa.busy}, 32'd1);
        drive_bit(1'b0, 1'b0, 54);
        drive_bit(1'b0, 1'b1, 7 * 27 + 10);
        chk("glitch_busy_lo", {31'd0, ifa.busy}, 32'd0);
        chk("glitch_no_pulses", (ferr_a - s_fe) + (perr_a - s_pe) + (ovr_a - s_ov) + (brk_a - s_br), 0);
        chk("glitch_no_valid", vrise_a - s_vr, 0);

        // Break of 12 bit periods, then a normal frame.
        snap();
        drive_bit(1'b0, 1'b0, 12 * 432);
        chk("brk_busy_during", {31'd0, ifa.busy}, 32'd1);
        drive_bit(1'b0, 1'b1, 8);
        chk("brk_busy_after", {31'd0, ifa.busy}, 32'd0);
        chk("brk_pulse", brk_a - s_br, 1);
        chk("brk_no_ferr", ferr_a - s_fe, 0);
        chk("brk_no_valid", vrise_a - s_vr, 0);
        drive_bit(1'b0, 1'b1, 100);
        send(1'b0, 8'h3C, -1, 1'b1);
        chk("after_brk_data", {24'd0, last_a}, 32'h3C);
        chk("after_brk_valid", vrise_a - s_vr, 1);

        // Reset in the middle of a frame.
        baud_div = 16'd3;
        snap();
        drive_bit(1'b0, 1'b0, 3 * 64);
        chk("mid_busy", {31'd0, ifa.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, ifa.busy}, 32'd0);
        drive_bit(1'b0, 1'b1, 3);
        rst = 1'b0;
        drive_bit(1'b0, 1'b1, 2 * 64);
        chk("mid_rst_no_valid", vrise_a - s_vr, 0);
        send(1'b0, 8'hC3, -1, 1'b1);
        chk("mid_rst_recover", {24'd0, last_a}, 32'hC3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter P_DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter P_PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 The block SHALL have parameter P_STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-004 The block SHALL have parameter P_DIV_W, default 16, width of baud_div.
REQ-005 The block SHALL have port clk input 1, clock.
REQ-006 The block SHALL have port rst input 1, asynchronous, active-high reset.
REQ-007 The block SHALL have port baud_div input P_DIV_W, clk cycles per oversample tick minus 1.
REQ-008 The block SHALL have port uart_in input 1, serial line, idle high.
REQ-009 The block SHALL have port rx_data output P_DATA_BITS, received word, LSB first on line.
REQ-010 The block SHALL have port rx_valid output 1, rx_data holds an unread word.
REQ-011 The block SHALL have port rx_ready input 1, consumer accepts rx_data.
REQ-012 The block SHALL have ports err_frame, err_parity, err_overrun, rx_break, each output 1, one-cycle error pulses.
REQ-013 The block SHALL have port busy output 1, high whenever FSM is not IDLE.

Function
REQ-014 uart_in SHALL pass a 2-flop synchronizer; all logic uses the synchronized value.
REQ-015 A tick SHALL occur every baud_div+1 clk cycles; one bit period = 16 ticks; baud_div is latched at start detection and held for the whole frame.
REQ-016 Each bit SHALL be resolved by 2-of-3 majority of samples at ticks 7, 8, 9 of that bit; the decision is taken at tick 9.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; PARITY is skipped when P_PARITY=0.
REQ-018 IDLE -> START on synchronized 1->0 transition; tick counter restarts at 0 on that transition.
REQ-019 START: majority high at tick 9 -> IDLE (false start, no flags); low -> DATA.
REQ-020 DATA: shift P_DATA_BITS bits LSB first, then PARITY or STOP.
REQ-021 PARITY: computed over data bits; mismatch sets a per-frame parity-error flag.
REQ-022 STOP: each of P_STOP_BITS sampled; any low stop bit marks framing error; FSM leaves STOP at tick 9 of last stop bit (no wait for bit end).
REQ-023 Break: all data bits, parity bit (if present) and all stop bits low -> rx_break pulse, no err_frame, no word delivered, enter BREAK; BREAK -> IDLE when synchronized line is high.
REQ-024 Frame end cycle = clk after last stop-bit decision; all completion effects occur there.
REQ-025 Framing error: err_frame pulse at frame end; word discarded; rx_valid unchanged.
REQ-026 Parity error without framing error: word delivered normally; err_parity pulses in the load cycle.
REQ-027 Load: rx_data <= word, rx_valid <= 1 if rx_valid=0 or (rx_valid & rx_ready) in that cycle.
REQ-028 Overrun: rx_valid=1 and rx_ready=0 at frame end -> err_overrun pulse, new word discarded, old rx_data kept.
REQ-029 rx_valid & rx_ready with no load SHALL clear rx_valid next cycle; rx_data retains its value.
REQ-030 For P_DATA_BITS<9 unused bits SHALL not exist; width exactly P_DATA_BITS.
REQ-031 baud_div=0 SHALL be legal (tick every clk).

Reset
REQ-032 rst SHALL force IDLE immediately, mid-frame included; partial frame discarded.
REQ-033 Reset values: rx_data 0, rx_valid 0, all error pulses 0, busy 0, synchronizer flops 1, counters 0.

Verification
REQ-034 8N1, baud_div=26, send 0xA5, rx_ready=1 -> rx_valid 1 cycle, rx_data=0xA5, no error pulses, busy falls at frame end.
REQ-035 P_PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, rx_valid=1, err_parity one pulse, err_frame 0.
REQ-036 8N1, send 0x55 with stop bit 0 -> err_frame one pulse, rx_valid stays 0.
REQ-037 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, err_overrun pulse at second frame end; rx_ready=1 -> rx_valid 0 next cycle.
REQ-038 Line low for 4 ticks then high -> no pulses, rx_valid 0, busy returns 0 by tick 10.
REQ-039 Line low 12 bit periods then high -> rx_break one pulse, no rx_valid, busy 0 after line high; following 0x3C received correctly.
